// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// word size and wait-counter width.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WAIT_W     = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store unit (master) and dmem_responder (slave).
// DMEM_BYTE_STROBE_EN adds the req_be byte-lane enables.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
`ifdef DMEM_BYTE_STROBE_EN
    output req_be,
`endif
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
`ifdef DMEM_BYTE_STROBE_EN
    input  req_be,
`endif
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Word RAM: synchronous per-byte write, combinational read. Contents are not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Stalling data-memory responder: one request in flight, WAIT_CYCLES wait states,
// registered response with range/alignment error. Optional DMEM_BYTE_STROBE_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned       AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]       DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_L  = WAIT_W'(WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    write_q;
  logic [31:0]             addr_q, wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
  logic [WORD_BYTES-1:0]   be_q;
`endif

  logic                    accept, commit, mem_we;
  logic                    acc_write, acc_err;
  logic [31:0]             acc_addr, acc_wdata, off;
  logic [WORD_BYTES-1:0]   acc_be;
  logic [31:0]             mem_rdata;

  assign accept = bus.req_valid && ready_q;

  // With zero wait states the access happens on the accepting edge itself, so the
  // live bus fields are used in IDLE and the latched copies afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      acc_be    = bus.req_be;
`else
      acc_be    = '1;
`endif
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
      acc_be    = be_q;
`else
      acc_be    = '1;
`endif
    end
  end

  // ADDR_BASE is word aligned, so the offset's low bits equal the address's.
  assign off     = acc_addr - ADDR_BASE;
  assign acc_err = (|off[1:0]) || ({2'b00, off[31:2]} >= DEPTH_L);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_L;
          state_d = (WAIT_L != '0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    commit  = (state_d == ST_RESP) && (state_q != ST_RESP);
    mem_we  = commit && acc_write && !acc_err;
    if (commit) begin
      rsp_valid_d = 1'b1;
      err_d       = acc_err;
      rdata_d     = (!acc_write && !acc_err) ? mem_rdata : '0;
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
        be_q    <= bus.req_be;
`endif
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (acc_be),
    .addr_i  (off[AW+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
// with a queue of expected responses; byte-strobe steps need DMEM_BYTE_STROBE_EN.
module tb_dmem_responder;

  localparam int unsigned WAITS = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t sb[$];

  dmem_responder_if m();
  dmem_responder_if m0();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAITS), .ADDR_BASE(32'h0000_0000))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(m));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_BASE(32'h0000_0000))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input int unsigned hold);
    exp_t e;
    int unsigned lat;
    logic ok;
    sb.push_back('{exp_rd, exp_err});
    m.rsp_ready = (hold == 0);
    @(negedge clk);
    m.req_valid = 1'b1;
    m.req_write = wr;
    m.req_addr  = addr;
    m.req_wdata = wd;
`ifdef DMEM_BYTE_STROBE_EN
    m.req_be    = be;
`endif
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m.req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept_timeout", 32'(ok), 32'd1);
    if (!ok) begin
      m.req_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    m.req_valid = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m.rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("rsp_timeout", 32'(ok), 32'd1);
    if (!ok) return;
    check("latency", lat, WAITS + 1);
    check("rdata", m.rsp_rdata, e.rdata);
    check("err", 32'(m.rsp_err), 32'(e.err));
    if (hold > 0) begin
      // A competing store to 0x10 is presented while the response is stalled.
      m.req_valid = 1'b1;
      m.req_write = 1'b1;
      m.req_addr  = 32'h10;
      m.req_wdata = 32'hBAD0_BAD0;
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 32'(m.rsp_valid), 32'd1);
        check("hold_rdata", m.rsp_rdata, e.rdata);
        check("hold_err", 32'(m.rsp_err), 32'(e.err));
        check("hold_ready", 32'(m.req_ready), 32'd0);
      end
      m.req_valid = 1'b0;
      m.rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("idle_valid", 32'(m.rsp_valid), 32'd0);
    check("idle_rdata", m.rsp_rdata, 32'd0);
    check("idle_ready", 32'(m.req_ready), 32'd1);
  endtask

  task automatic do_req0(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
    exp_t e;
    sb.push_back('{exp_rd, 1'b0});
    @(negedge clk);
    m0.req_valid = 1'b1;
    m0.req_write = wr;
    m0.req_addr  = addr;
    m0.req_wdata = wd;
    check("w0_ready", 32'(m0.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    m0.req_valid = 1'b0;
    e = sb.pop_front();
    check("w0_latency1_valid", 32'(m0.rsp_valid), 32'd1);
    check("w0_rdata", m0.rsp_rdata, e.rdata);
    check("w0_err", 32'(m0.rsp_err), 32'(e.err));
    @(negedge clk);
    check("w0_idle_valid", 32'(m0.rsp_valid), 32'd0);
  endtask

  initial begin
    m.req_valid = 1'b0; m.req_write = 1'b0; m.req_addr = '0; m.req_wdata = '0; m.rsp_ready = 1'b1;
    m0.req_valid = 1'b0; m0.req_write = 1'b0; m0.req_addr = '0; m0.req_wdata = '0; m0.rsp_ready = 1'b1;
`ifdef DMEM_BYTE_STROBE_EN
    m.req_be = 4'hF;
    m0.req_be = 4'hF;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(m.req_ready), 32'd0);
    check("rst_valid", 32'(m.rsp_valid), 32'd0);
    check("rst_rdata", m.rsp_rdata, 32'd0);
    check("rst_err", 32'(m.rsp_err), 32'd0);
    check("rst_ready0", 32'(m0.req_ready), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", 32'(m.req_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_after_edge", 32'(m.req_ready), 32'd1);

    // Store then load
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h10, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 0);

    // Errors: misaligned, out of range, range-error store leaves neighbour intact
    do_req(1'b1, 32'h3FC, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h13,  32'h0,         4'hF, 32'h0, 1'b1, 0);
    do_req(1'b0, 32'h400, 32'h0,         4'hF, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'h402, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req(1'b0, 32'h3FC, 32'h0,         4'hF, 32'h5A5A_5A5A, 1'b0, 0);

    // Backpressure, then confirm the store offered during the stall was ignored
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 5);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);

    // Reset in the middle of a store's wait states
    do_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clk);
    m.rsp_ready = 1'b1;
    m.req_valid = 1'b1; m.req_write = 1'b1; m.req_addr = 32'h20; m.req_wdata = 32'h1234_5678;
    check("midwait_ready", 32'(m.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    m.req_valid = 1'b0;
    check("midwait_in_wait", 32'(m.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_valid", 32'(m.rsp_valid), 32'd0);
    check("midwait_rst_ready", 32'(m.req_ready), 32'd0);
    check("midwait_rst_rdata", m.rsp_rdata, 32'd0);
    check("midwait_rst_err", 32'(m.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 0);

    // Zero-wait instance
    do_req0(1'b1, 32'h40, 32'h600D_CAFE, 32'h0);
    do_req0(1'b0, 32'h40, 32'h0,         32'h600D_CAFE);

`ifdef DMEM_BYTE_STROBE_EN
    do_req(1'b1, 32'h30, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 0);
    do_req(1'b1, 32'h30, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h30, 32'h0, 4'b0000, 32'hAA22_CC44, 1'b0, 0);
    do_req(1'b1, 32'h30, 32'h9999_9999, 4'b0000, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h30, 32'h0, 4'hF, 32'hAA22_CC44, 1'b0, 0);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
